// File: rtl/plc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : plc_pkg
// Description : Shared FSM state encoding and fault codes for plc_scan_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
package plc_pkg;

  typedef logic [1:0] fault_code_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CPU_RST = 3'd1;
  localparam logic [2:0] ST_INPUT   = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_OUTPUT  = 3'd4;
  localparam logic [2:0] ST_WAIT    = 3'd5;
  localparam logic [2:0] ST_FAULT   = 3'd6;

  localparam fault_code_t FC_NONE    = 2'b00;
  localparam fault_code_t FC_WDT     = 2'b01;
  localparam fault_code_t FC_CPU_ERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/plc_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : plc_scan_ctrl_if
// Description : Scan controller <-> CPU handshake bundle.
// Revision    : 1.0  initial release
// ============================================================================
interface plc_scan_ctrl_if;

  logic cpu_halt_in;
  logic cpu_err_in;
  logic cpu_rst;
  logic cpu_run;
  logic in_latch;
  logic out_update;

  modport master (
    input  cpu_halt_in, cpu_err_in,
    output cpu_rst, cpu_run, in_latch, out_update
  );

  modport slave (
    output cpu_halt_in, cpu_err_in,
    input  cpu_rst, cpu_run, in_latch, out_update
  );

endinterface
`default_nettype wire

// File: rtl/scan_wdt.sv
`default_nettype none
// ============================================================================
// Module      : scan_wdt
// Description : EXECUTE-cycle counter doubling as watchdog; saturates at max.
// Revision    : 1.0  initial release
// ============================================================================
module scan_wdt #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             expired_o,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + ONE_W;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q excludes the current cycle, so the limit-th cycle sees limit-1
  assign expired_o = enable_i && (limit_i != '0) && (count_q >= (limit_i - ONE_W));
  assign count_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/plc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : plc_scan_ctrl
// Description : PLC scan-cycle sequencer: reset CPU, latch inputs, execute,
//               update outputs, pace to scan period, trap watchdog/CPU errors.
// Revision    : 1.0  initial release
// ============================================================================
module plc_scan_ctrl
  import plc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic               ack_fault_in,
  input  logic [WIDTH-1:0]   scan_period_in,
  input  logic [WIDTH-1:0]   wdt_limit_in,
  plc_scan_ctrl_if.master    cpu,
  output logic               busy,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic               overrun,
  output logic [WIDTH-1:0]   scan_count,
  output logic [WIDTH-1:0]   last_scan_len
);

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [2:0]       state_q, state_d;
  fault_code_t      fcode_q, fcode_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] period_q, wdt_lim_q;
  logic [WIDTH-1:0] scan_cnt_q, last_len_q;

  logic             w_expired;
  logic [WIDTH-1:0] w_exec_len;
  logic             w_period_on;
  logic             w_per_reached;

  scan_wdt #(.WIDTH(WIDTH)) u_wdt (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clear_i   (state_q == ST_CPU_RST),
    .enable_i  (state_q == ST_EXECUTE),
    .limit_i   (wdt_lim_q),
    .expired_o (w_expired),
    .count_o   (w_exec_len)
  );

  assign w_period_on   = (period_q != '0);
  assign w_per_reached = (per_q >= (period_q - ONE_W));

  always_comb begin
    state_d   = state_q;
    fcode_d   = fcode_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE:    if (start_in) state_d = ST_CPU_RST;
      ST_CPU_RST: state_d = ST_INPUT;
      ST_INPUT:   state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        // error beats halt, halt beats watchdog
        if (cpu.cpu_err_in) begin
          state_d = ST_FAULT;
          fcode_d = FC_CPU_ERR;
        end else if (cpu.cpu_halt_in) begin
          state_d = ST_OUTPUT;
        end else if (w_expired) begin
          state_d = ST_FAULT;
          fcode_d = FC_WDT;
        end
      end
      ST_OUTPUT: begin
        if (w_period_on && w_per_reached) overrun_d = 1'b1;
        state_d = start_in ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        if (!w_period_on || w_per_reached) begin
          state_d = start_in ? ST_CPU_RST : ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (ack_fault_in && !start_in) begin
          state_d   = ST_IDLE;
          fcode_d   = FC_NONE;
          overrun_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    per_d = per_q;
    if (state_d == ST_CPU_RST && state_q != ST_CPU_RST) begin
      per_d = '0;
    end else if (per_q != '1) begin
      per_d = per_q + ONE_W;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      fcode_q    <= FC_NONE;
      overrun_q  <= 1'b0;
      per_q      <= '0;
      period_q   <= '0;
      wdt_lim_q  <= '0;
      scan_cnt_q <= '0;
      last_len_q <= '0;
    end else begin
      state_q   <= state_d;
      fcode_q   <= fcode_d;
      overrun_q <= overrun_d;
      per_q     <= per_d;
      if (state_q == ST_CPU_RST) begin
        period_q  <= scan_period_in;
        wdt_lim_q <= wdt_limit_in;
      end
      if (state_q == ST_OUTPUT) begin
        scan_cnt_q <= scan_cnt_q + ONE_W;
        last_len_q <= w_exec_len;
      end
    end
  end

  // decoded from state so an asynchronous reset drops them immediately
  assign cpu.cpu_rst    = (state_q == ST_CPU_RST);
  assign cpu.in_latch   = (state_q == ST_INPUT);
  assign cpu.cpu_run    = (state_q == ST_EXECUTE);
  assign cpu.out_update = (state_q == ST_OUTPUT);

  assign busy          = (state_q != ST_IDLE) && (state_q != ST_FAULT);
  assign fault         = (state_q == ST_FAULT);
  assign fault_code    = fcode_q;
  assign overrun       = overrun_q;
  assign scan_count    = scan_cnt_q;
  assign last_scan_len = last_len_q;

endmodule
`default_nettype wire

// File: tb/tb_plc_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_plc_scan_ctrl
// Description : Randomized scan-level bench for plc_scan_ctrl, plus a narrow
//               instance exercising counter wrap and length saturation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_plc_scan_ctrl;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance
  logic         rst_n, start, ack;
  logic [W-1:0] per, wdt;
  logic         busy, fault, overrun;
  logic [1:0]   fcode;
  logic [W-1:0] scnt, slen;
  plc_scan_ctrl_if m_if();

  plc_scan_ctrl #(.WIDTH(W)) dut (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .ack_fault_in(ack),
    .scan_period_in(per), .wdt_limit_in(wdt), .cpu(m_if),
    .busy(busy), .fault(fault), .fault_code(fcode), .overrun(overrun),
    .scan_count(scnt), .last_scan_len(slen)
  );

  // narrow instance: free-running, halt one cycle into EXECUTE when enabled
  logic       s_rst_n, s_start, s_halt_en;
  logic       s_busy, s_fault, s_ovr;
  logic [1:0] s_fcode;
  logic [3:0] s_scnt, s_slen;
  plc_scan_ctrl_if s_if();
  assign s_if.cpu_halt_in = s_if.cpu_run & s_halt_en;
  assign s_if.cpu_err_in  = 1'b0;

  plc_scan_ctrl #(.WIDTH(4)) dut_s (
    .clk_in(clk), .rst_in(s_rst_n), .start_in(s_start), .ack_fault_in(1'b0),
    .scan_period_in(4'd0), .wdt_limit_in(4'd0), .cpu(s_if),
    .busy(s_busy), .fault(s_fault), .fault_code(s_fcode), .overrun(s_ovr),
    .scan_count(s_scnt), .last_scan_len(s_slen)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", tag, act, req);
  endtask

  // reference model state (scan-level)
  int exp_cnt  = 0;
  int exp_len  = 0;
  bit exp_ovr  = 0;
  bit have_prev = 0;
  int prev_t0  = 0;
  int prev_gap = 0;

  task automatic wait_cpu_rst(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_if.cpu_rst) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // p: period, wl: watchdog limit, h/e: EXECUTE cycle of halt/err (0 = never),
  // keep: start_in stays high, rst_at: EXECUTE cycle to pull reset (0 = never)
  task automatic do_scan(input int p, input int wl, input int h, input int e,
                         input bit keep, input int rst_at);
    bit ok;
    int endc, kind, t0;
    endc = 1 << 30;
    if (e > 0) endc = e;
    if (h > 0 && h < endc) endc = h;
    if (wl > 0 && wl < endc) endc = wl;
    kind = (e > 0 && e == endc) ? 2 : ((h > 0 && h == endc) ? 0 : 1);

    start = 1'b1;
    wait_cpu_rst(ok);
    chk("cpu_rst_seen", ok, 1);
    if (!ok) return;
    t0 = cyc;
    if (have_prev) chk("scan_gap", t0 - prev_t0, prev_gap);
    have_prev = 0;
    per = W'(p);
    wdt = W'(wl);
    m_if.cpu_halt_in = 1'($urandom);
    m_if.cpu_err_in  = 1'($urandom);

    @(negedge clk);
    chk("in_latch", m_if.in_latch, 1);
    per = W'($urandom);
    wdt = W'($urandom);
    m_if.cpu_halt_in = 1'($urandom);
    m_if.cpu_err_in  = 1'($urandom);

    for (int k = 1; k <= endc; k++) begin
      @(negedge clk);
      chk("cpu_run", m_if.cpu_run, 1);
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cpu_run", m_if.cpu_run, 0);
        chk("rst_busy", busy, 0);
        chk("rst_scan_count", scnt, 0);
        chk("rst_last_len", slen, 0);
        chk("rst_out_update", m_if.out_update, 0);
        exp_cnt = 0; exp_len = 0; exp_ovr = 0; have_prev = 0;
        start = 1'b0;
        m_if.cpu_halt_in = 1'b0;
        m_if.cpu_err_in  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_no_out", m_if.out_update, 0);
        chk("post_rst_idle", busy, 0);
        return;
      end
      if (k == 1 && !keep) start = 1'b0;
      m_if.cpu_halt_in = (k == h);
      m_if.cpu_err_in  = (k == e);
    end

    @(negedge clk);
    m_if.cpu_halt_in = 1'($urandom);
    m_if.cpu_err_in  = 1'($urandom);
    if (kind == 0) begin
      chk("out_update", m_if.out_update, 1);
      exp_cnt = (exp_cnt + 1) % 65536;
      exp_len = (endc > 65535) ? 65535 : endc;
      if (p != 0 && p <= endc + 3) exp_ovr = 1;
      @(negedge clk);
      chk("scan_count", scnt, exp_cnt);
      chk("last_len", slen, exp_len);
      chk("overrun", overrun, exp_ovr);
      chk("busy_after_out", busy, keep);
      if (keep) begin
        have_prev = 1;
        prev_t0   = t0;
        prev_gap  = (p > endc + 4) ? p : endc + 4;
      end
    end else begin
      chk("fault", fault, 1);
      chk("fault_code", fcode, (kind == 2) ? 2 : 1);
      chk("fault_run", m_if.cpu_run, 0);
      chk("fault_out", m_if.out_update, 0);
      chk("fault_busy", busy, 0);
      chk("fault_scan_count", scnt, exp_cnt);
      ack = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      chk("fault_hold", fault, 1);
      start = 1'b0;
      @(negedge clk);
      exp_ovr = 0;
      chk("ack_fault", fault, 0);
      chk("ack_code", fcode, 0);
      chk("ack_overrun", overrun, exp_ovr);
      chk("ack_busy", busy, 0);
      ack = 1'b0;
    end
    m_if.cpu_halt_in = 1'b0;
    m_if.cpu_err_in  = 1'b0;
  endtask

  initial begin
    bit ok;
    int p, wl, h, e;
    rst_n = 1'b0; start = 1'b0; ack = 1'b0; per = '0; wdt = '0;
    m_if.cpu_halt_in = 1'b0; m_if.cpu_err_in = 1'b0;
    s_rst_n = 1'b0; s_start = 1'b0; s_halt_en = 1'b1;
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_fault", fault, 0);
    chk("reset_code", fcode, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_count", scnt, 0);
    chk("reset_len", slen, 0);
    chk("reset_run", m_if.cpu_run, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_scan(20, 0, 5, 0, 1, 0);
    do_scan(20, 0, 5, 0, 1, 0);
    do_scan(8, 0, 12, 0, 1, 0);
    do_scan(8, 0, 12, 0, 1, 0);
    do_scan(0, 10, 0, 0, 1, 0);
    do_scan(0, 0, 4, 4, 1, 0);
    do_scan(0, 5, 5, 0, 1, 0);
    do_scan(0, 0, 6, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      p  = $urandom_range(0, 30);
      h  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 20);
      wl = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 25);
      e  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : 0;
      if (h == 0 && wl == 0) h = 5;
      do_scan(p, wl, h, e, ($urandom_range(0, 5) != 0), 0);
    end

    do_scan(0, 0, 10, 0, 1, 3);
    do_scan(15, 0, 3, 0, 1, 0);

    @(negedge clk);
    start = 1'b0;
    s_rst_n = 1'b1;
    s_start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      ok = 1'b0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (s_if.out_update) begin
          ok = 1'b1;
          break;
        end
      end
      chk("wrap_out_seen", ok, 1);
      @(negedge clk);
      chk("wrap_count", s_scnt, i % 16);
    end
    chk("narrow_len", s_slen, 1);
    s_halt_en = 1'b0;
    repeat (25) @(negedge clk);
    s_halt_en = 1'b1;
    ok = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (s_if.out_update) begin
        ok = 1'b1;
        break;
      end
    end
    chk("sat_out_seen", ok, 1);
    @(negedge clk);
    chk("sat_len", s_slen, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/plc_scan_ctrl.md
PLC_SCAN_CTRL -- requirements
Module: plc_scan_ctrl

Interface
REQ-001 Parameter WIDTH, 16, width of the period, watchdog, count and length fields.
REQ-002 clk_in  input  1  single clock; all state changes on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-low.
REQ-004 start_in  input  1  level; 1 = run scan cycles continuously, 0 = stop after current scan.
REQ-005 cpu_halt_in  input  1  CPU end-of-program pulse (HALT instruction decoded).
REQ-006 cpu_err_in  input  1  CPU error (stack full on push / empty on pop).
REQ-007 ack_fault_in  input  1  operator fault acknowledge.
REQ-008 scan_period_in  input  WIDTH  scan period in clk_in cycles; 0 = free-running.
REQ-009 wdt_limit_in  input  WIDTH  max EXECUTE cycles; 0 = watchdog disabled.
REQ-010 cpu_rst  output  1  one-cycle program-counter/stack reset pulse.
REQ-011 cpu_run  output  1  CPU clock-enable, high only in EXECUTE.
REQ-012 in_latch  output  1  one-cycle pulse: sample a0_io/d0..d3 into input image.
REQ-013 out_update  output  1  one-cycle pulse: drive output image to pins.
REQ-014 busy  output  1  high in every state except IDLE and FAULT.
REQ-015 fault  output  1  high in FAULT.
REQ-016 fault_code  output  2  00 none, 01 watchdog, 10 CPU error; held until acknowledged.
REQ-017 overrun  output  1  sticky: a scan exceeded scan_period_in.
REQ-018 scan_count  output  WIDTH  completed scans, wraps all-ones -> 0.
REQ-019 last_scan_len  output  WIDTH  EXECUTE cycle count of last completed scan, saturating.

Function
REQ-020 FSM states SHALL be IDLE, CPU_RST, INPUT, EXECUTE, OUTPUT, WAIT, FAULT.
REQ-021 IDLE -> CPU_RST when start_in=1; CPU_RST and INPUT SHALL each last exactly one cycle (cpu_rst, in_latch asserted during them).
REQ-022 EXECUTE: cpu_run=1 each cycle; exits to OUTPUT on the cycle after cpu_halt_in=1 is sampled.
REQ-023 cpu_halt_in and cpu_err_in SHALL be ignored outside EXECUTE.
REQ-024 OUTPUT lasts one cycle: out_update=1, scan_count increments, last_scan_len loaded.
REQ-025 After OUTPUT: start_in=0 -> IDLE; else -> WAIT.
REQ-026 Period counter SHALL clear on entry to CPU_RST and increment every cycle until next CPU_RST; WAIT exits to CPU_RST on the cycle the counter equals scan_period_in-1.
REQ-027 If the counter is already >= scan_period_in-1 at OUTPUT (scan_period_in!=0), WAIT SHALL last one cycle and overrun SHALL set.
REQ-028 scan_period_in=0: WAIT lasts one cycle, overrun never set.
REQ-029 Watchdog counter counts EXECUTE cycles; reaching wdt_limit_in without halt -> FAULT, fault_code=01.
REQ-030 Halt and watchdog expiry in the same cycle: halt wins (normal OUTPUT).
REQ-031 cpu_err_in=1 in EXECUTE -> FAULT, fault_code=10; err wins over halt and watchdog in the same cycle.
REQ-032 FAULT: cpu_run, cpu_rst, in_latch, out_update all 0; exit to IDLE only when ack_fault_in=1 and start_in=0; fault_code clears on that exit.
REQ-033 overrun SHALL clear only on reset or on FAULT acknowledge.
REQ-034 Inputs scan_period_in, wdt_limit_in SHALL be sampled at CPU_RST and held for the scan.

Reset
REQ-035 rst_in=0 SHALL immediately force IDLE, all outputs 0, all counters 0, independent of clk_in.
REQ-036 Reset mid-EXECUTE SHALL drop cpu_run the same instant; no out_update is issued for the aborted scan.

Structure
REQ-037 State encoding and fault_code constants SHALL live in shared package plc_pkg.
REQ-038 Watchdog/exec-length counter SHALL be sub-module scan_wdt (clear, enable, limit, expired, count).

Verification
REQ-039 start_in=1, period=20, halt after 5 EXECUTE cycles -> cpu_rst at t0, next cpu_rst at t0+20, last_scan_len=5, scan_count increments per scan.
REQ-040 period=8, halt after 12 cycles -> overrun=1, WAIT one cycle, scanning continues.
REQ-041 wdt_limit=10, no halt -> FAULT after 10 EXECUTE cycles, fault_code=01, cpu_run=0; ack with start_in=0 -> IDLE, fault_code=00.
REQ-042 cpu_err_in and cpu_halt_in same cycle -> FAULT, fault_code=10; halt and wdt expiry same cycle -> OUTPUT.
REQ-043 start_in dropped mid-EXECUTE -> scan completes with out_update, then IDLE; rst_in low mid-EXECUTE -> all outputs 0 asynchronously.
REQ-044 scan_count preset to all-ones via 65535 scans (period 0) -> wraps to 0.
